// File: rtl/bus_timeout_pkg.sv
// Shared types and constants for the single-outstanding bus timeout controller.
package bus_timeout_pkg;

  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_e;

  typedef enum logic {
    PH_ADDR = 1'b0,
    PH_DATA = 1'b1
  } phase_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Phase wait counter: flags expiry in the limit-th waiting cycle of a phase.
// r_cnt holds the waiting cycles already elapsed; the current cycle is r_cnt+1.
module bus_timeout_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic [CNT_WIDTH-1:0] i_limit,
  output logic                 o_expired_c
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_cur;

  assign w_cnt_cur   = r_cnt + CNT_WIDTH'(1);
  assign o_expired_c = i_enable && (i_limit != '0) && (w_cnt_cur == i_limit);

  // Stops at the limit so the count never wraps, even with limit 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable) begin
      r_cnt <= '0;
    end else if (w_cnt_cur != i_limit) begin
      r_cnt <= w_cnt_cur;
    end
  end

endmodule

// File: rtl/bus_timeout_ctrl.sv
// Single-outstanding bus passthrough that times address and data phases,
// answers the master with an error on timeout and drains the late response.
module bus_timeout_ctrl
  import bus_timeout_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_enable_i,
  input  logic [CNT_WIDTH-1:0] cfg_limit_i,
  input  logic                 cfg_irq_clr_i,
  input  logic                 cfg_flush_i,
  input  logic                 m_req_i,
  input  logic [BUS_WIDTH-1:0] m_addr_i,
  output logic                 m_gnt_o,
  output logic                 m_rvalid_o,
  output logic                 m_err_o,
  output logic                 s_req_o,
  output logic [BUS_WIDTH-1:0] s_addr_o,
  input  logic                 s_gnt_i,
  input  logic                 s_rvalid_i,
  output logic                 timeout_irq_o,
  output logic [BUS_WIDTH-1:0] fault_addr_o,
  output logic                 fault_phase_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 busy_o
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_stale;
  logic [CNT_WIDTH-1:0]   r_lim;
  logic [BUS_WIDTH-1:0]   r_addr;
  logic                   r_irq;
  logic [BUS_WIDTH-1:0]   r_fault_addr;
  phase_e                 r_fault_phase;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic                   w_s_req;
  logic                   w_m_gnt;
  logic                   w_m_rvalid;
  logic                   w_m_err;
  logic                   w_capture;
  logic                   w_cnt_clr;
  logic                   w_expired;
  logic                   w_err_enter;
  phase_e                 w_err_phase;

  bus_timeout_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_clear     (w_cnt_clr),
    .i_enable    (cfg_enable_i),
    .i_limit     (r_lim),
    .o_expired_c (w_expired)
  );

  // Next state and the combinational passthrough paths.
  always_comb begin
    w_state_nxt = r_state;
    w_s_req     = 1'b0;
    w_m_gnt     = 1'b0;
    w_m_rvalid  = 1'b0;
    w_m_err     = 1'b0;
    w_capture   = 1'b0;
    w_cnt_clr   = 1'b1;
    w_err_enter = 1'b0;
    w_err_phase = PH_ADDR;
    case (r_state)
      IDLE: begin
        if (!r_stale) begin
          w_s_req = m_req_i;
          w_m_gnt = m_req_i & s_gnt_i;
          if (m_req_i) begin
            w_capture   = 1'b1;
            w_state_nxt = s_gnt_i ? DATA : ADDR;
          end
        end
      end
      ADDR: begin
        w_s_req = m_req_i;
        w_m_gnt = m_req_i & s_gnt_i;
        if (m_req_i && s_gnt_i) begin
          w_state_nxt = DATA;
        end else if (!m_req_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_clr = 1'b0;
          if (w_expired) begin
            w_state_nxt = ERR;
            w_err_enter = 1'b1;
            w_err_phase = PH_ADDR;
          end
        end
      end
      DATA: begin
        w_m_rvalid = s_rvalid_i;
        if (s_rvalid_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_clr = 1'b0;
          if (w_expired) begin
            w_state_nxt = ERR;
            w_err_enter = 1'b1;
            w_err_phase = PH_DATA;
          end
        end
      end
      ERR: begin
        w_m_rvalid  = 1'b1;
        w_m_err     = 1'b1;
        w_m_gnt     = (r_fault_phase == PH_ADDR);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transaction capture, quarantine and fault reporting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lim         <= '0;
      r_addr        <= '0;
      r_stale       <= 1'b0;
      r_irq         <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_phase <= PH_ADDR;
      r_err_cnt     <= '0;
    end else begin
      if (w_capture) begin
        r_lim  <= cfg_limit_i;
        r_addr <= m_addr_i;
      end
      if (w_err_enter && (w_err_phase == PH_DATA)) begin
        r_stale <= 1'b1;
      end else if (s_rvalid_i || cfg_flush_i) begin
        r_stale <= 1'b0;
      end
      if (w_err_enter) begin
        r_irq         <= 1'b1;
        r_fault_addr  <= r_addr;
        r_fault_phase <= w_err_phase;
        if (r_err_cnt != ERR_CNT_MAX) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end else if (cfg_irq_clr_i) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign s_req_o       = w_s_req;
  assign s_addr_o      = m_addr_i;
  assign m_gnt_o       = w_m_gnt;
  assign m_rvalid_o    = w_m_rvalid;
  assign m_err_o       = w_m_err;
  assign timeout_irq_o = r_irq;
  assign fault_addr_o  = r_fault_addr;
  assign fault_phase_o = r_fault_phase;
  assign err_cnt_o     = r_err_cnt;
  assign busy_o        = (r_state != IDLE) || r_stale;

endmodule

// File: tb/tb_bus_timeout_ctrl.sv
// Directed and randomized checks of bus_timeout_ctrl against a
// transaction-level reference model kept in this bench.
module tb_bus_timeout_ctrl;

  localparam int unsigned BW = 32;
  localparam int unsigned CW = 16;

  // Reference model transaction modes.
  localparam int M_IDLE     = 0;
  localparam int M_WAIT_GNT = 1;
  localparam int M_WAIT_RSP = 2;
  localparam int M_ERR_BEAT = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_enable_i;
  logic [CW-1:0] cfg_limit_i;
  logic          cfg_irq_clr_i;
  logic          cfg_flush_i;
  logic          m_req_i;
  logic [BW-1:0] m_addr_i;
  logic          m_gnt_o;
  logic          m_rvalid_o;
  logic          m_err_o;
  logic          s_req_o;
  logic [BW-1:0] s_addr_o;
  logic          s_gnt_i;
  logic          s_rvalid_i;
  logic          timeout_irq_o;
  logic [BW-1:0] fault_addr_o;
  logic          fault_phase_o;
  logic [7:0]    err_cnt_o;
  logic          busy_o;

  bus_timeout_ctrl #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cfg_enable_i  (cfg_enable_i),
    .cfg_limit_i   (cfg_limit_i),
    .cfg_irq_clr_i (cfg_irq_clr_i),
    .cfg_flush_i   (cfg_flush_i),
    .m_req_i       (m_req_i),
    .m_addr_i      (m_addr_i),
    .m_gnt_o       (m_gnt_o),
    .m_rvalid_o    (m_rvalid_o),
    .m_err_o       (m_err_o),
    .s_req_o       (s_req_o),
    .s_addr_o      (s_addr_o),
    .s_gnt_i       (s_gnt_i),
    .s_rvalid_i    (s_rvalid_i),
    .timeout_irq_o (timeout_irq_o),
    .fault_addr_o  (fault_addr_o),
    .fault_phase_o (fault_phase_o),
    .err_cnt_o     (err_cnt_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state.
  int            md_mode;
  int            md_waited;
  int            md_lim;
  logic [BW-1:0] md_addr;
  bit            md_stale;
  bit            md_irq;
  logic [BW-1:0] md_faddr;
  bit            md_fphase;
  int            md_errs;
  bit            ex_sreq, ex_gnt, ex_rv, ex_err;
  bit            smp_sreq, smp_gnt, smp_rv, smp_err;

  task automatic model_reset();
    md_mode = M_IDLE; md_waited = 0; md_lim = 0; md_addr = '0;
    md_stale = 0; md_irq = 0; md_faddr = '0; md_fphase = 0; md_errs = 0;
  endtask

  task automatic model_comb();
    ex_sreq = 0; ex_gnt = 0; ex_rv = 0; ex_err = 0;
    case (md_mode)
      M_IDLE:     if (!md_stale) begin ex_sreq = m_req_i; ex_gnt = m_req_i && s_gnt_i; end
      M_WAIT_GNT: begin ex_sreq = m_req_i; ex_gnt = m_req_i && s_gnt_i; end
      M_WAIT_RSP: ex_rv = s_rvalid_i;
      default:    begin ex_rv = 1; ex_err = 1; ex_gnt = (md_fphase == 0); end
    endcase
  endtask

  // One waiting cycle of a phase; true when the wait has reached the limit.
  function automatic bit waited_out();
    md_waited = cfg_enable_i ? md_waited + 1 : 0;
    return cfg_enable_i && (md_lim != 0) && (md_waited >= md_lim);
  endfunction

  task automatic model_edge();
    bit hit;
    bit ph;
    bit stale_n;
    hit = 0; ph = 0;
    stale_n = md_stale;
    if (cfg_flush_i || s_rvalid_i) stale_n = 0;
    case (md_mode)
      M_IDLE: if (!md_stale && m_req_i) begin
        md_lim = int'(cfg_limit_i); md_addr = m_addr_i; md_waited = 0;
        md_mode = s_gnt_i ? M_WAIT_RSP : M_WAIT_GNT;
      end
      M_WAIT_GNT: begin
        if (m_req_i && s_gnt_i) begin md_mode = M_WAIT_RSP; md_waited = 0; end
        else if (!m_req_i) md_mode = M_IDLE;
        else if (waited_out()) begin hit = 1; ph = 0; end
      end
      M_WAIT_RSP: begin
        if (s_rvalid_i) md_mode = M_IDLE;
        else if (waited_out()) begin hit = 1; ph = 1; end
      end
      default: md_mode = M_IDLE;
    endcase
    if (hit) begin
      md_mode = M_ERR_BEAT; md_irq = 1; md_faddr = md_addr; md_fphase = ph;
      if (md_errs < 255) md_errs++;
      if (ph) stale_n = 1;
    end else if (cfg_irq_clr_i) begin
      md_irq = 0;
    end
    md_stale = stale_n;
  endtask

  // One clock: inputs already driven just after the previous edge.
  task automatic tick();
    #2;
    model_comb();
    smp_sreq = s_req_o; smp_gnt = m_gnt_o; smp_rv = m_rvalid_o; smp_err = m_err_o;
    check("s_req", s_req_o, ex_sreq);
    check("m_gnt", m_gnt_o, ex_gnt);
    check("m_rvalid", m_rvalid_o, ex_rv);
    check("m_err", m_err_o, ex_err);
    check("s_addr", s_addr_o, m_addr_i);
    @(posedge clk_i);
    model_edge();
    #1;
    check("irq", timeout_irq_o, md_irq);
    check("fault_addr", fault_addr_o, md_faddr);
    check("fault_phase", fault_phase_o, md_fphase);
    check("err_cnt", err_cnt_o, md_errs);
    check("busy", busy_o, (md_mode != M_IDLE) || md_stale);
  endtask

  task automatic apply_reset();
    rst_i = 1; m_req_i = 0; s_gnt_i = 0; s_rvalid_i = 0;
    cfg_irq_clr_i = 0; cfg_flush_i = 0;
    #1;
    model_reset();
    check("rst_irq", timeout_irq_o, 0);
    check("rst_fault_addr", fault_addr_o, 0);
    check("rst_fault_phase", fault_phase_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_s_req", s_req_o, 0);
    check("rst_m_gnt", m_gnt_o, 0);
    check("rst_m_rvalid", m_rvalid_o, 0);
    check("rst_m_err", m_err_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit last_gnt;
    cfg_enable_i = 1; cfg_limit_i = '0; m_addr_i = '0;
    apply_reset();

    // Normal passthrough.
    cfg_limit_i = 4; m_req_i = 1; m_addr_i = 32'h2000_0010; s_gnt_i = 0; tick();
    s_gnt_i = 1; tick(); check("norm_gnt", smp_gnt, 1);
    m_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; tick();
    check("norm_rv", smp_rv, 1); check("norm_err", smp_err, 0);
    s_rvalid_i = 0; check("norm_irq", timeout_irq_o, 0);

    // Address-phase timeout, L=3: error beat in cycle 4.
    cfg_limit_i = 3; m_req_i = 1; m_addr_i = 32'h1000_0040;
    repeat (4) tick();
    check("atmo_err_early", smp_err, 0);
    tick();
    check("atmo_gnt", smp_gnt, 1); check("atmo_rv", smp_rv, 1); check("atmo_err", smp_err, 1);
    check("atmo_irq", timeout_irq_o, 1); check("atmo_faddr", fault_addr_o, 32'h1000_0040);
    check("atmo_phase", fault_phase_o, 0); check("atmo_cnt", err_cnt_o, 1);
    m_req_i = 0;
    cfg_irq_clr_i = 1; tick(); cfg_irq_clr_i = 0;
    check("irq_clr", timeout_irq_o, 0);

    // Data-phase timeout, L=2, then late response drained.
    cfg_limit_i = 2; m_req_i = 1; m_addr_i = 32'h3000_0000; s_gnt_i = 1; tick();
    m_req_i = 0; s_gnt_i = 0; tick(); tick(); tick();
    check("dtmo_rv", smp_rv, 1); check("dtmo_err", smp_err, 1); check("dtmo_gnt", smp_gnt, 0);
    check("dtmo_phase", fault_phase_o, 1); check("dtmo_faddr", fault_addr_o, 32'h3000_0000);
    check("dtmo_busy", busy_o, 1);
    m_req_i = 1; m_addr_i = 32'h3000_0100; s_gnt_i = 1; tick();
    check("stale_sreq", smp_sreq, 0); check("stale_gnt", smp_gnt, 0);
    s_rvalid_i = 1; tick();
    check("stale_drop_rv", smp_rv, 0);
    check("stale_cleared", busy_o, 0);
    s_rvalid_i = 0; tick();
    check("post_stale_sreq", smp_sreq, 1); check("post_stale_gnt", smp_gnt, 1);
    m_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; tick(); s_rvalid_i = 0;

    // Grant in the limit cycle wins.
    cfg_limit_i = 3; m_req_i = 1; m_addr_i = 32'h4000_0000; repeat (3) tick();
    s_gnt_i = 1; tick();
    check("lim_gnt", smp_gnt, 1); check("lim_cnt", err_cnt_o, 2);
    m_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; tick(); s_rvalid_i = 0;

    // Limit 0 never times out.
    cfg_limit_i = 0; m_req_i = 1; repeat (100) tick();
    check("lim0_cnt", err_cnt_o, 2); check("lim0_busy", busy_o, 1);
    s_gnt_i = 1; tick(); m_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; tick(); s_rvalid_i = 0;

    // Checking disabled: neither phase times out.
    cfg_enable_i = 0; cfg_limit_i = 2; m_req_i = 1; repeat (10) tick();
    s_gnt_i = 1; tick(); m_req_i = 0; s_gnt_i = 0; repeat (10) tick();
    check("dis_cnt", err_cnt_o, 2);
    s_rvalid_i = 1; tick(); s_rvalid_i = 0; cfg_enable_i = 1;

    // Timeout set beats irq clear in the same cycle.
    cfg_irq_clr_i = 1; tick(); cfg_irq_clr_i = 0;
    cfg_limit_i = 1; m_req_i = 1; m_addr_i = 32'h5000_0000; tick();
    cfg_irq_clr_i = 1; tick(); cfg_irq_clr_i = 0;
    check("clr_vs_set_irq", timeout_irq_o, 1); check("clr_vs_set_cnt", err_cnt_o, 3);
    tick(); m_req_i = 0;

    // Flush clears quarantine without a response.
    m_req_i = 1; s_gnt_i = 1; tick(); m_req_i = 0; s_gnt_i = 0; tick(); tick();
    check("flush_pre_busy", busy_o, 1);
    cfg_flush_i = 1; tick(); cfg_flush_i = 0;
    check("flush_busy", busy_o, 0);
    m_req_i = 1; s_gnt_i = 1; tick(); check("flush_sreq", smp_sreq, 1);
    m_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; tick(); s_rvalid_i = 0;

    // Error counter saturation.
    cfg_limit_i = 1;
    repeat (300) begin
      m_req_i = 1; tick(); tick(); tick();
    end
    m_req_i = 0;
    check("sat_cnt", err_cnt_o, 255);

    // Async reset while in the data phase, then a clean transaction.
    cfg_limit_i = 4; m_req_i = 1; s_gnt_i = 1; tick();
    m_req_i = 0; s_gnt_i = 0; tick();
    apply_reset();
    m_req_i = 1; m_addr_i = 32'h6000_0000; s_gnt_i = 1; tick(); check("rst_after_gnt", smp_gnt, 1);
    m_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; tick();
    check("rst_after_rv", smp_rv, 1); check("rst_after_err", smp_err, 0);
    s_rvalid_i = 0;

    // Randomized traffic against the model.
    last_gnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!m_req_i) begin
        if ($urandom_range(2) == 0) begin m_req_i = 1; m_addr_i = $urandom; end
      end else if (last_gnt || $urandom_range(49) == 0) begin
        m_req_i = 0;
      end
      s_gnt_i       = ($urandom_range(3) == 0);
      s_rvalid_i    = ($urandom_range(2) == 0);
      cfg_limit_i   = CW'($urandom_range(5));
      cfg_enable_i  = ($urandom_range(9) != 0);
      cfg_irq_clr_i = ($urandom_range(19) == 0);
      cfg_flush_i   = ($urandom_range(39) == 0);
      tick();
      last_gnt = ex_gnt;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_timeout_ctrl.md
# bus_timeout_ctrl

Single-outstanding bus transaction controller that sits between one core-side master port and the system bus. It passes requests and responses through, and times each address phase and data phase against a programmable limit. On a timeout it completes the transaction towards the master with an error response. It then quarantines the bus until the late slave response is drained, and raises a sticky interrupt for the watchdog CSR logic.

## Interface
- BUS_WIDTH, 32, address width
- CNT_WIDTH, 16, phase counter / limit width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cfg_enable_i  in  1  timeout checking enable; 0 = pure passthrough, counter held at 0
- cfg_limit_i  in  CNT_WIDTH  max wait cycles per phase; 0 = never time out
- cfg_irq_clr_i  in  1  pulse, clears timeout_irq_o
- cfg_flush_i  in  1  pulse, clears the stale-response quarantine
- m_req_i  in  1  master request; held until m_gnt_o
- m_addr_i  in  BUS_WIDTH  master address
- m_gnt_o  out  1  grant to master
- m_rvalid_o  out  1  response valid to master
- m_err_o  out  1  error response, qualified by m_rvalid_o
- s_req_o  out  1  request to slave
- s_addr_o  out  BUS_WIDTH  address to slave (= m_addr_i)
- s_gnt_i  in  1  slave grant
- s_rvalid_i  in  1  slave response valid
- timeout_irq_o  out  1  sticky timeout interrupt
- fault_addr_o  out  BUS_WIDTH  address of the last timed-out transaction
- fault_phase_o  out  1  0 = address-phase timeout, 1 = data-phase timeout
- err_cnt_o  out  8  saturating count of timeouts
- busy_o  out  1  state != IDLE or stale set

## Operation
- FSM states are IDLE, ADDR, DATA and ERR. A separate stale flag marks that a late slave response is still owed.
- Combinational paths in IDLE/ADDR with stale=0:
  - s_req_o = m_req_i
  - m_gnt_o = s_req_o & s_gnt_i
  - In DATA, m_rvalid_o = s_rvalid_i and m_err_o = 0.
- IDLE:
  - s_req_o & s_gnt_i → DATA.
  - s_req_o only → ADDR. Capture m_addr_i into addr_q.
  - In both cases, capture cfg_limit_i into lim_q and clear the counter.
- ADDR:
  - s_gnt_i → DATA, counter cleared.
  - m_req_i dropped → IDLE; this is a protocol violation, tolerated, with no error.
  - Otherwise the counter increments.
  - Timeout when the counter == lim_q, lim_q != 0 and cfg_enable_i=1 → ERR with phase 0.
- DATA:
  - s_rvalid_i → IDLE.
  - Otherwise the counter increments.
  - Timeout under the same rule → ERR with phase 1 and stale set.
- ERR lasts one cycle and always returns to IDLE.
  - Phase 0: m_gnt_o=1, m_rvalid_o=1, m_err_o=1, s_req_o=0.
  - Phase 1: m_rvalid_o=1, m_err_o=1.
- Stale handling:
  - While stale=1 in IDLE: s_req_o=0, m_gnt_o=0, and slave responses are not forwarded.
  - s_rvalid_i clears stale and the response is dropped.
  - cfg_flush_i also clears stale.
- Entering ERR performs these updates together:
  - set timeout_irq_o
  - load fault_addr_o ← addr_q and fault_phase_o
  - increment err_cnt_o, saturating at 255
- Simultaneous events:
  - The awaited event (s_gnt_i / s_rvalid_i) in the limit cycle wins, so there is no timeout.
  - Timeout set beats cfg_irq_clr_i.
  - s_rvalid_i and cfg_flush_i in the same cycle simply clear stale.
- Counter width rules:
  - The counter is CNT_WIDTH bits and never wraps, because it stops at lim_q.
  - lim_q is CNT_WIDTH bits.
- cfg_enable_i=0 mid-phase: the counter holds at 0 and the FSM still tracks phases; no timeout can fire.

## Timing
- Reset values are 0 for: state=IDLE, stale, counter, lim_q, addr_q, and all outputs.
- Passthrough adds zero latency (combinational req/gnt/rvalid paths).
- With lim_q = L, the address phase times out when no grant has arrived in the L cycles after the request cycle. m_err_o is asserted in cycle L+1 after first request.
- The data phase counts the same way, starting from the cycle after the grant.
- Exactly one transaction is outstanding. A new request can be granted in the cycle after the IDLE return, but not in the same cycle as the response.
- An async reset mid-transaction aborts immediately. A late slave response after reset is not tracked.

## Structure
- bus_timeout_pkg holds:
  - the state enum (IDLE, ADDR, DATA, ERR)
  - the phase enum (PH_ADDR=0, PH_DATA=1)
  - the err_cnt saturation constant
- Sub-module bus_timeout_counter (CNT_WIDTH) provides:
  - inputs: clear, enable, limit
  - output: expired = (cnt == limit) & (limit != 0)

## Test plan
- Normal: L=4, the slave grants at cycle 1 and responds at cycle 2 → m_gnt_o and m_rvalid_o pass through, m_err_o=0, irq=0.
- Address timeout: L=3, s_gnt_i never asserted, addr 0x1000_0040 → m_gnt_o, m_rvalid_o and m_err_o all =1 at cycle 4. Also irq=1, fault_addr_o=0x1000_0040, fault_phase_o=0, err_cnt_o=1.
- Data timeout with a late response:
  - L=2, grant then no rvalid → error response at cycle 3 and stale=1.
  - A new m_req_i is held off with s_req_o=0.
  - A late s_rvalid_i is dropped (m_rvalid_o=0), and the next request is then forwarded.
- Boundary: s_gnt_i arrives exactly in the limit cycle → no timeout. L=0 with 100 waiting cycles → no timeout. cfg_enable_i=0 → no timeout.
- Irq and counter:
  - cfg_irq_clr_i in the same cycle as a new ERR entry → irq stays 1.
  - 300 timeouts → err_cnt_o=255.
  - cfg_flush_i clears stale without any s_rvalid_i.
- Reset: assert rst_i in the DATA state → all outputs 0 and state IDLE on the next edge; a new transaction then completes normally.
